packet_sorter: RTL

Next-generation packet sorter for the Avalon-ST datapath. Buffers one packet of up to MAX_PKT_LEN words, sorts it by a configurable key field in ascending or descending order (stable: equal keys keep arrival order), then streams it out honouring full src_ready backpressure. It sits inline between an Avalon-ST source and sink. Compared with the previous sorter, it adds key/payload split, a per-packet direction, overflow flagging and output backpressure.

---
 rtl/packet_sorter_pkg.sv | 23 ++
 rtl/packet_sorter_ram.sv | 31 +++
 rtl/packet_sorter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_sorter_pkg.sv
// Shared types and helpers for packet_sorter.
//   state_e          : top-level FSM states
//   cnt_width()      : width of counters holding 0..max_len
//   key_out_of_order : strict order violation test used by the swap engine
package packet_sorter_pkg;

  typedef enum logic [1:0] {RECV, SORT, SEND} state_e;

  // Widest key the compare helper accepts; callers zero-extend to this width.
  localparam int unsigned KEY_MAX_W = 1024;

  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // Strict comparison only, so equal keys never swap and the sort stays stable.
  function automatic logic key_out_of_order(input logic [KEY_MAX_W-1:0] key_a,
                                            input logic [KEY_MAX_W-1:0] key_b,
                                            input logic                 descending);
    return descending ? (key_a < key_b) : (key_a > key_b);
  endfunction

endpackage

// File: rtl/packet_sorter_ram.sv
// Simple dual-port packet buffer, DEPTH x DWIDTH, one write port and one
// registered read port (1-cycle latency).
//   clk_i   : clock
//   we_i    : write enable, waddr_i/wdata_i : write address/data
//   raddr_i : read address, rdata_o : read data (registered)
module packet_sorter_ram
  import packet_sorter_pkg::*;
#(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/packet_sorter.sv
// Avalon-ST packet sorter: buffers one packet, bubble-sorts it by the key
// field data[KEY_WIDTH-1:0] (stable, per-packet direction) and streams it out
// with full backpressure.
//   clk_i, arst_n_i          : clock, asynchronous active-low reset
//   snk_*                    : Avalon-ST sink (data/sop/eop/valid/ready)
//   snk_descending_i         : sort direction, sampled with SOP
//   src_*                    : Avalon-ST source; src_error_o flags truncation on EOP
module packet_sorter
  import packet_sorter_pkg::*;
#(
  parameter int unsigned DWIDTH      = 64,
  parameter int unsigned KEY_WIDTH   = DWIDTH,
  parameter int unsigned MAX_PKT_LEN = 128
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  input  logic              snk_descending_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  output logic              src_error_o,
  input  logic              src_ready_i
);

  localparam int unsigned CW      = cnt_width(MAX_PKT_LEN);
  localparam int unsigned AW      = $clog2(MAX_PKT_LEN);
  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_PKT_LEN);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {PH_LD, PH_CMP, PH_FIN} phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic              rst_done_q;
  logic              in_pkt_q, in_pkt_d;
  logic              desc_q, desc_d;
  logic              ovf_q, ovf_d;
  logic              swapped_q, swapped_d;
  logic              vld_q, vld_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     bound_q, bound_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [DWIDTH-1:0] cur_q, cur_d;

  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [DWIDTH-1:0] ram_wdata, ram_rdata;

  logic              snk_accept;
  logic              room;
  logic              do_swap;

  packet_sorter_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MAX_PKT_LEN),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign snk_accept = snk_valid_i && snk_ready_o;
  assign room       = wr_cnt_q < MAX_LEN;
  assign do_swap    = key_out_of_order(KEY_MAX_W'(cur_q[KEY_WIDTH-1:0]),
                                       KEY_MAX_W'(ram_rdata[KEY_WIDTH-1:0]), desc_q);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= RECV;
      phase_q    <= PH_LD;
      rst_done_q <= 1'b0;
      in_pkt_q   <= 1'b0;
      desc_q     <= 1'b0;
      ovf_q      <= 1'b0;
      swapped_q  <= 1'b0;
      vld_q      <= 1'b0;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      j_q        <= '0;
      bound_q    <= '0;
      ptr_q      <= '0;
      cur_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rst_done_q <= 1'b1;
      in_pkt_q   <= in_pkt_d;
      desc_q     <= desc_d;
      ovf_q      <= ovf_d;
      swapped_q  <= swapped_d;
      vld_q      <= vld_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      j_q        <= j_d;
      bound_q    <= bound_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    in_pkt_d  = in_pkt_q;
    desc_d    = desc_q;
    ovf_d     = ovf_q;
    swapped_d = swapped_q;
    vld_d     = vld_q;
    wr_cnt_d  = wr_cnt_q;
    len_d     = len_q;
    j_d       = j_q;
    bound_d   = bound_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = snk_data_i;
    ram_raddr = '0;

    unique case (state_q)
      RECV: begin
        if (snk_accept) begin
          if (snk_startofpacket_i) begin
            ram_we   = 1'b1;
            wr_cnt_d = ONE;
            in_pkt_d = 1'b1;
            desc_d   = snk_descending_i;
            ovf_d    = 1'b0;
            if (snk_endofpacket_i) begin
              len_d    = ONE;
              in_pkt_d = 1'b0;
              wr_cnt_d = '0;
              vld_d    = 1'b0;
              state_d  = SEND;
            end
          end else if (in_pkt_q) begin
            if (room) begin
              ram_we    = 1'b1;
              ram_waddr = AW'(wr_cnt_q);
              wr_cnt_d  = wr_cnt_q + ONE;
            end else begin
              ovf_d = 1'b1;
            end
            if (snk_endofpacket_i) begin
              // Length is at least 2 here; read address 0 is already issued
              // by the default, so the sort starts directly in PH_LD.
              len_d     = room ? wr_cnt_q + ONE : wr_cnt_q;
              bound_d   = room ? wr_cnt_q + ONE : wr_cnt_q;
              in_pkt_d  = 1'b0;
              wr_cnt_d  = '0;
              phase_d   = PH_LD;
              state_d   = SORT;
            end
          end
        end
      end

      // Carry scheme: cur_q holds the element destined for slot j while
      // mem[j+1] streams in; each step writes back exactly one slot, and the
      // read of j+2 overlaps the write of j.
      SORT: begin
        unique case (phase_q)
          PH_LD: begin
            cur_d     = ram_rdata;
            j_d       = '0;
            swapped_d = 1'b0;
            ram_raddr = AW'(1);
            phase_d   = PH_CMP;
          end
          PH_CMP: begin
            ram_we    = 1'b1;
            ram_waddr = AW'(j_q);
            ram_wdata = do_swap ? ram_rdata : cur_q;
            cur_d     = do_swap ? cur_q : ram_rdata;
            swapped_d = swapped_q | do_swap;
            if ((j_q + CW'(2)) == bound_q) begin
              phase_d = PH_FIN;
            end else begin
              j_d       = j_q + ONE;
              ram_raddr = AW'(j_q + CW'(2));
            end
          end
          PH_FIN: begin
            ram_we    = 1'b1;
            ram_waddr = AW'(bound_q - ONE);
            ram_wdata = cur_q;
            if (!swapped_q || bound_q == CW'(2)) begin
              vld_d   = 1'b0;
              ptr_d   = '0;
              state_d = SEND;
            end else begin
              bound_d = bound_q - ONE;
              phase_d = PH_LD;
            end
          end
          default: phase_d = PH_LD;
        endcase
      end

      // Output data comes straight from the RAM read register; re-reading
      // the same address while stalled keeps src_data_o stable.
      SEND: begin
        if (!vld_q) begin
          vld_d = 1'b1;
          ptr_d = '0;
        end else if (src_ready_i) begin
          if (ptr_q == len_q - ONE) begin
            vld_d   = 1'b0;
            state_d = RECV;
          end else begin
            ptr_d     = ptr_q + ONE;
            ram_raddr = AW'(ptr_q + ONE);
          end
        end else begin
          ram_raddr = AW'(ptr_q);
        end
      end

      default: state_d = RECV;
    endcase
  end

  always_comb begin
    snk_ready_o         = rst_done_q && (state_q == RECV);
    src_valid_o         = vld_q;
    src_data_o          = vld_q ? ram_rdata : '0;
    src_startofpacket_o = vld_q && (ptr_q == '0);
    src_endofpacket_o   = vld_q && (ptr_q == len_q - ONE);
    src_error_o         = vld_q && (ptr_q == len_q - ONE) && ovf_q;
  end

endmodule
